mux41_rr_arbiter: RTL



---
 rtl/mux41_rr_arbiter_pkg.sv | 27 ++
 rtl/mux41_rr_arbiter_rr_pick4.sv | 32 +++
 rtl/mux41_rr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared constants for the 4:1 mux arbiter and the display blocks: state
// encoding and active-low seven-segment patterns {dp,g,f,e,d,c,b,a}.
package mux41_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;

  function automatic logic [7:0] seg_digit(input logic [1:0] idx);
    logic [7:0] pattern;
    case (idx)
      2'd0:    pattern = SEG_0;
      2'd1:    pattern = SEG_1;
      2'd2:    pattern = SEG_2;
      default: pattern = SEG_3;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first unmasked request at or
// after ptr (modulo 4) wins.
module rr_pick4
  import mux41_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       any
);

  logic [3:0] elig;

  assign elig = req & ~mask;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    logic [1:0] pos;
    idx = 2'd0;
    any = 1'b0;
    pos = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      pos = ptr + 2'(k);
      if (elig[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter owning the select of the shared 4:1 mux, with a
// bounded hold time per owner and a seven-segment owner display.
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] sel,
  output logic [7:0] seg0
);

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [7:0]       seg_reg, seg_next;

  logic       owner_req;
  logic       at_limit;
  logic       force_rot;
  logic [3:0] mask;
  logic [1:0] pick_idx;
  logic       pick_any;

  assign owner_req = req[sel_reg];
  assign at_limit  = (cnt_reg == CNT_W'(HOLD_MAX));
  assign force_rot = (state_reg == ST_GRANT) && owner_req && at_limit;

  // Only a forced rotation hides the owner; a dropped owner has req low anyway.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign mask[gi] = force_rot && (sel_reg == 2'(gi));
    end
  endgenerate

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_reg),
    .mask (mask),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      cnt_reg   <= '0;
      gnt_reg   <= 4'b0000;
      seg_reg   <= SEG_BLANK;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      seg_reg   <= seg_next;
    end
  end

  always_comb begin
    logic take;
    take       = 1'b0;
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    seg_next   = seg_reg;
    case (state_reg)
      ST_IDLE: begin
        take = pick_any;
      end
      default: begin
        if (owner_req && !at_limit) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (owner_req) begin
          take = pick_any;  // no challenger: keep grant, counter stays saturated
        end else if (pick_any) begin
          take = 1'b1;
        end else begin
          state_next = ST_IDLE;
          gnt_next   = 4'b0000;
          seg_next   = SEG_BLANK;
          cnt_next   = '0;
        end
      end
    endcase
    if (take) begin
      state_next = ST_GRANT;
      sel_next   = pick_idx;
      gnt_next   = 4'b0001 << pick_idx;
      cnt_next   = CNT_W'(1);
      ptr_next   = pick_idx + 2'd1;
      seg_next   = seg_digit(pick_idx);
    end
  end

  always_comb begin
    gnt       = gnt_reg;
    gnt_valid = |gnt_reg;
    sel       = sel_reg;
    seg0      = seg_reg;
  end

endmodule
